// File: rtl/gain_ramp_ctrl_pkg.sv
// Register map, CTRL bit positions and FSM states for the gain ramp controller.
package gain_ramp_ctrl_pkg;

  localparam logic [19:0] REG_TARGET = 20'h0;
  localparam logic [19:0] REG_SHIFT  = 20'h4;
  localparam logic [19:0] REG_CTRL   = 20'h8;
  localparam logic [19:0] REG_STATUS = 20'hC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/gain_ramp_ctrl.sv
// Ctrlport-programmed gain ramp: steps gain from its current value to TARGET
// over 2^SHIFT consumed samples using a fixed-point accumulator.
module gain_ramp_ctrl
  import gain_ramp_ctrl_pkg::*;
#(
  parameter int GAIN_W    = 16,
  parameter int FRAC_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int INIT_GAIN = 1
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic              sample_adv,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_update,
  output logic              busy
);

  localparam int          ACC_W = GAIN_W + FRAC_W + 2;
  localparam logic [19:0] BASE  = 20'(BASE_ADDR);

  state_t                    state_q, state_d;
  logic [GAIN_W-1:0]         target_q, gain_q, gain_d, ramp_tgt_q, ramp_tgt_d;
  logic [3:0]                shift_q, ramp_shift_q, ramp_shift_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, step;
  logic signed [GAIN_W:0]    delta_q, delta_d, delta_new;
  logic [15:0]               count_q, count_d;
  logic                      ack_q, gain_update_q;
  logic [31:0]               rdata_q, rd_mux;
  logic [19:0]               offset;
  logic [7:0]                shamt;
  logic                      hit, wr_hit, rd_hit, start, abort;
  logic                      unused_data;

  // Only the four word-aligned registers of the window are acknowledged.
  assign offset = s_ctrlport_req_addr - BASE;
  assign hit    = (offset[19:4] == 16'd0) && (offset[1:0] == 2'd0);
  assign wr_hit = s_ctrlport_req_wr && hit;
  assign rd_hit = s_ctrlport_req_rd && hit;
  assign start  = wr_hit && (offset == REG_CTRL) && s_ctrlport_req_data[CTRL_START_BIT];
  assign abort  = wr_hit && (offset == REG_CTRL) && s_ctrlport_req_data[CTRL_ABORT_BIT];
  assign unused_data = ^s_ctrlport_req_data;

  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_TARGET: rd_mux[GAIN_W-1:0] = target_q;
      REG_SHIFT:  rd_mux[3:0]        = shift_q;
      REG_STATUS: begin
        rd_mux[GAIN_W-1:0]      = gain_q;
        rd_mux[STATUS_BUSY_BIT] = (state_q == ST_RAMP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      target_q <= GAIN_W'(INIT_GAIN);
      shift_q  <= 4'd0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      ack_q   <= (s_ctrlport_req_wr || s_ctrlport_req_rd) && hit;
      rdata_q <= rd_hit ? rd_mux : 32'd0;
      if (wr_hit && offset == REG_TARGET) target_q <= s_ctrlport_req_data[GAIN_W-1:0];
      if (wr_hit && offset == REG_SHIFT)  shift_q  <= s_ctrlport_req_data[3:0];
    end
  end

  assign delta_new = $signed({1'b0, target_q}) - $signed({1'b0, gain_q});
  assign shamt     = 8'(FRAC_W) - {4'd0, ramp_shift_q};
  assign step      = $signed({{(ACC_W-GAIN_W-1){delta_q[GAIN_W]}}, delta_q}) <<< shamt;

  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    acc_d        = acc_q;
    delta_d      = delta_q;
    count_d      = count_q;
    ramp_tgt_d   = ramp_tgt_q;
    ramp_shift_d = ramp_shift_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start) begin
      if (shift_q == 4'd0 || delta_new == '0) begin
        gain_d  = target_q;
        state_d = ST_IDLE;
      end else begin
        delta_d                 = delta_new;
        acc_d                   = '0;
        acc_d[FRAC_W +: GAIN_W] = gain_q;
        count_d                 = 16'd1 << shift_q;
        ramp_tgt_d              = target_q;
        ramp_shift_d            = shift_q;
        state_d                 = ST_RAMP;
      end
    end else if (state_q == ST_RAMP && sample_adv) begin
      count_d = count_q - 16'd1;
      acc_d   = acc_q + step;
      // The last step lands exactly on the target, hiding rounding residue.
      if (count_q == 16'd1) begin
        gain_d  = ramp_tgt_q;
        state_d = ST_IDLE;
      end else begin
        gain_d = acc_d[FRAC_W +: GAIN_W];
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      state_q       <= ST_IDLE;
      gain_q        <= GAIN_W'(INIT_GAIN);
      acc_q         <= '0;
      delta_q       <= '0;
      count_q       <= 16'd0;
      ramp_tgt_q    <= GAIN_W'(INIT_GAIN);
      ramp_shift_q  <= 4'd0;
      gain_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      acc_q         <= acc_d;
      delta_q       <= delta_d;
      count_q       <= count_d;
      ramp_tgt_q    <= ramp_tgt_d;
      ramp_shift_q  <= ramp_shift_d;
      gain_update_q <= (gain_d != gain_q);
    end
  end

  assign s_ctrlport_resp_ack  = ack_q;
  assign s_ctrlport_resp_data = rdata_q;
  assign gain                 = gain_q;
  assign gain_update          = gain_update_q;
  assign busy                 = (state_q == ST_RAMP);

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed bench for gain_ramp_ctrl: inputs change and outputs are sampled on
// the falling edge, so every result seen is one rising edge after its cause.
module tb_gain_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0, rd = 1'b0, sadv = 1'b0;
  logic [19:0] addr = 20'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack, gain_update, busy;
  logic [31:0] rdata;
  logic [15:0] gain;

  int          total = 0;
  int          bad = 0;
  logic        last_ack;
  logic [31:0] last_rdata;

  gain_ramp_ctrl #(.GAIN_W(16), .FRAC_W(16), .BASE_ADDR(0), .INIT_GAIN(1)) dut (
    .ce_clk(clk), .ce_rst_n(rst_n),
    .s_ctrlport_req_wr(wr), .s_ctrlport_req_rd(rd),
    .s_ctrlport_req_addr(addr), .s_ctrlport_req_data(wdata),
    .s_ctrlport_resp_ack(ack), .s_ctrlport_resp_data(rdata),
    .sample_adv(sadv), .gain(gain), .gain_update(gain_update), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk); wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0; last_ack = ack;
  endtask

  task automatic bus_rd(input logic [19:0] a);
    @(negedge clk); rd = 1'b1; addr = a;
    @(negedge clk); rd = 1'b0; last_ack = ack; last_rdata = rdata;
  endtask

  task automatic pulse();
    @(negedge clk); sadv = 1'b1;
    @(negedge clk); sadv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (gain !== 16'h0001) begin bad++; $display("FAIL rst_gain got=%h exp=0001", gain); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (ack !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL rst_resp ack=%b data=%h exp 0/0", ack, rdata); end
    total++; if (gain_update !== 1'b0) begin bad++; $display("FAIL rst_upd got=%b exp=0", gain_update); end
    rst_n = 1'b1;
    bus_rd(20'hC);
    total++; if (last_ack !== 1'b1 || last_rdata !== 32'h0000_0001) begin bad++; $display("FAIL rst_status ack=%b data=%h exp 1/00000001", last_ack, last_rdata); end
    bus_rd(20'h0);
    total++; if (last_rdata !== 32'h1) begin bad++; $display("FAIL rst_target got=%h exp=00000001", last_rdata); end
    bus_rd(20'h4);
    total++; if (last_rdata !== 32'h0) begin bad++; $display("FAIL rst_shift got=%h exp=00000000", last_rdata); end
  endtask

  task automatic test_up_ramp();
    logic [15:0] exp_g [4] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100};
    bus_wr(20'h0, 32'h100); bus_wr(20'h4, 32'd2); bus_wr(20'h8, 32'h1);
    total++; if (busy !== 1'b1 || gain !== 16'h1) begin bad++; $display("FAIL up_start busy=%b gain=%h exp 1/0001", busy, gain); end
    for (int i = 0; i < 4; i++) begin
      pulse();
      total++; if (gain !== exp_g[i] || gain_update !== 1'b1) begin bad++; $display("FAIL up_step%0d gain=%h upd=%b exp %h/1", i, gain, gain_update, exp_g[i]); end
      total++; if (busy !== (i < 3)) begin bad++; $display("FAIL up_busy%0d got=%b exp=%b", i, busy, (i < 3)); end
    end
    pulse();
    total++; if (gain !== 16'h0100 || gain_update !== 1'b0) begin bad++; $display("FAIL up_idle_adv gain=%h upd=%b exp 0100/0", gain, gain_update); end
    bus_rd(20'hC);
    total++; if (last_rdata !== 32'h0000_0100) begin bad++; $display("FAIL up_status got=%h exp=00000100", last_rdata); end
  endtask

  task automatic test_down_ramp();
    int          ucnt = 0;
    logic [15:0] prev;
    logic [15:0] exp_g;
    bus_wr(20'h0, 32'h0); bus_wr(20'h4, 32'd3); bus_wr(20'h8, 32'h1);
    prev = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      pulse();
      if (gain_update === 1'b1) ucnt++;
      exp_g = (i == 7) ? 16'h0 : 16'(256 - 32 * (i + 1));
      total++; if (gain !== exp_g || !(gain < prev)) begin bad++; $display("FAIL down_step%0d gain=%h prev=%h exp=%h", i, gain, prev, exp_g); end
      prev = gain;
    end
    total++; if (ucnt != 8) begin bad++; $display("FAIL down_updates got=%0d exp=8", ucnt); end
    total++; if (busy !== 1'b0 || gain !== 16'h0) begin bad++; $display("FAIL down_end busy=%b gain=%h exp 0/0000", busy, gain); end
  endtask

  task automatic test_abort();
    bus_wr(20'h0, 32'h1); bus_wr(20'h4, 32'd0); bus_wr(20'h8, 32'h1);
    total++; if (gain !== 16'h1 || gain_update !== 1'b1) begin bad++; $display("FAIL ab_setup gain=%h upd=%b exp 0001/1", gain, gain_update); end
    bus_wr(20'h0, 32'h100); bus_wr(20'h4, 32'd2); bus_wr(20'h8, 32'h1);
    pulse(); pulse();
    total++; if (gain !== 16'h0080) begin bad++; $display("FAIL ab_pre gain=%h exp=0080", gain); end
    bus_wr(20'h8, 32'h2);
    total++; if (gain !== 16'h0080 || busy !== 1'b0 || last_ack !== 1'b1) begin bad++; $display("FAIL ab_hold gain=%h busy=%b ack=%b exp 0080/0/1", gain, busy, last_ack); end
    pulse(); pulse();
    total++; if (gain !== 16'h0080 || gain_update !== 1'b0) begin bad++; $display("FAIL ab_adv gain=%h upd=%b exp 0080/0", gain, gain_update); end
    bus_wr(20'h8, 32'h3);
    total++; if (busy !== 1'b0 || gain !== 16'h0080) begin bad++; $display("FAIL ab_wins busy=%b gain=%h exp 0/0080", busy, gain); end
  endtask

  task automatic test_shift0();
    bus_wr(20'h0, 32'h7FFF); bus_wr(20'h4, 32'd0); bus_wr(20'h8, 32'h1);
    total++; if (gain !== 16'h7FFF || gain_update !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL s0_jump gain=%h upd=%b busy=%b exp 7fff/1/0", gain, gain_update, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0 || gain_update !== 1'b0) begin bad++; $display("FAIL s0_quiet%0d busy=%b upd=%b exp 0/0", i, busy, gain_update); end
    end
    bus_wr(20'h8, 32'h1);
    total++; if (gain !== 16'h7FFF || gain_update !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL s0_same gain=%h upd=%b busy=%b exp 7fff/0/0", gain, gain_update, busy); end
  endtask

  task automatic test_restart();
    bus_wr(20'h0, 32'h100); bus_wr(20'h8, 32'h1);
    bus_wr(20'h0, 32'h200); bus_wr(20'h4, 32'd1); bus_wr(20'h8, 32'h1);
    pulse();
    total++; if (gain !== 16'h0180 || busy !== 1'b1) begin bad++; $display("FAIL rs_half gain=%h busy=%b exp 0180/1", gain, busy); end
    bus_wr(20'h0, 32'h0); bus_wr(20'h4, 32'd3);
    pulse();
    total++; if (gain !== 16'h0200 || busy !== 1'b0) begin bad++; $display("FAIL rs_deferred gain=%h busy=%b exp 0200/0", gain, busy); end
    bus_wr(20'h8, 32'h1);
    pulse();
    total++; if (gain !== 16'h01C0) begin bad++; $display("FAIL rs_first gain=%h exp=01c0", gain); end
    bus_wr(20'h8, 32'h1);
    pulse();
    total++; if (gain !== 16'h0188 || busy !== 1'b1) begin bad++; $display("FAIL rs_restart gain=%h busy=%b exp 0188/1", gain, busy); end
    bus_wr(20'h8, 32'h2);
    @(negedge clk); wr = 1'b1; addr = 20'h8; wdata = 32'h1; sadv = 1'b1;
    @(negedge clk); wr = 1'b0; sadv = 1'b0;
    total++; if (gain !== 16'h0188 || busy !== 1'b1) begin bad++; $display("FAIL rs_start_adv gain=%h busy=%b exp 0188/1", gain, busy); end
    bus_wr(20'h8, 32'h2);
  endtask

  task automatic test_reset_midramp();
    bus_wr(20'h0, 32'h100); bus_wr(20'h4, 32'd2); bus_wr(20'h8, 32'h1);
    pulse();
    total++; if (gain !== 16'h0166) begin bad++; $display("FAIL mr_step gain=%h exp=0166", gain); end
    @(negedge clk); rst_n = 1'b0; wr = 1'b1; addr = 20'h0; wdata = 32'h55;
    @(negedge clk); rst_n = 1'b1; wr = 1'b0;
    total++; if (gain !== 16'h0001 || busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL mr_reset gain=%h busy=%b ack=%b exp 0001/0/0", gain, busy, ack); end
    bus_rd(20'h0);
    total++; if (last_rdata !== 32'h1) begin bad++; $display("FAIL mr_target got=%h exp=00000001", last_rdata); end
    bus_wr(20'h10, 32'h1234);
    total++; if (last_ack !== 1'b0) begin bad++; $display("FAIL mr_noack0 ack=%b exp=0", last_ack); end
    repeat (2) begin
      @(negedge clk);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL mr_noack ack=%b exp=0", ack); end
    end
    bus_rd(20'h8);
    total++; if (last_ack !== 1'b1 || last_rdata !== 32'h0) begin bad++; $display("FAIL mr_ctrl_rd ack=%b data=%h exp 1/00000000", last_ack, last_rdata); end
    pulse();
    total++; if (gain !== 16'h0001 || busy !== 1'b0) begin bad++; $display("FAIL mr_idle gain=%h busy=%b exp 0001/0", gain, busy); end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_abort();
    test_shift0();
    test_restart();
    test_reset_midramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
